checksum_engine: RTL and testbench

Streaming, frame-based integrity engine; next generation of the single-mode LRC block. Consumes bytes over a valid/ready handshake and computes one of three selectable checks per frame: LRC, XOR parity, or FNV-1a at a parametrised hash width. The result is presented on a registered, back-pressurable result port with a byte count. Sits between the pad-level byte input and the output mux of the tile top.

---
 rtl/checksum_pkg.sv | 32 +++
 rtl/checksum_engine_if.sv | 30 +++
 rtl/fnv1a_step.sv | 28 ++
 rtl/checksum_engine.sv | 137 +++++++++++++
 tb/tb_checksum_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/checksum_pkg.sv
// Shared types and FNV-1a constants for the checksum engine.
package checksum_pkg;

    typedef enum logic [1:0] {
        MODE_LRC  = 2'b00,
        MODE_XOR  = 2'b01,
        MODE_FNV  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_e;

    localparam logic [31:0] FNV32_OFFSET = 32'h811C_9DC5;
    localparam logic [31:0] FNV32_PRIME  = 32'h0100_0193;
    localparam logic [63:0] FNV64_OFFSET = 64'hCBF2_9CE4_8422_2325;
    localparam logic [63:0] FNV64_PRIME  = 64'h0000_0100_0000_01B3;

    // Offset basis for a given hash width, widened to 64 bits.
    function automatic logic [63:0] fnv_offset(input int unsigned w);
        return (w == 64) ? FNV64_OFFSET : {32'h0, FNV32_OFFSET};
    endfunction

    // Prime for a given hash width, widened to 64 bits.
    function automatic logic [63:0] fnv_prime(input int unsigned w);
        return (w == 64) ? FNV64_PRIME : {32'h0, FNV32_PRIME};
    endfunction

endpackage

// File: rtl/checksum_engine_if.sv
// Byte-in / result-out bundle of the checksum engine.
interface checksum_engine_if #(
    parameter int unsigned HASH_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              clear;
    logic [1:0]        mode;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              res_valid;
    logic              res_ready;
    logic [HASH_W-1:0] res_data;
    logic [1:0]        res_mode;
    logic [CNT_W-1:0]  res_count;
    logic              res_err;

    // Producer of bytes and consumer of results.
    modport master (
        output clear, mode, in_data, in_valid, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_mode, res_count, res_err
    );

    // The engine itself.
    modport slave (
        input  clear, mode, in_data, in_valid, in_last, res_ready,
        output in_ready, res_valid, res_data, res_mode, res_count, res_err
    );
endinterface

// File: rtl/fnv1a_step.sv
// One FNV-1a round: h_next = (h ^ byte) * prime mod 2^HASH_W, as a shift-add tree.
module fnv1a_step
    import checksum_pkg::*;
#(
    parameter int unsigned HASH_W = 32
) (
    input  logic [HASH_W-1:0] h_i,
    input  logic [7:0]        byte_i,
    output logic [HASH_W-1:0] h_next_o
);
    localparam logic [63:0]       PrimeFull = fnv_prime(HASH_W);
    localparam logic [HASH_W-1:0] Prime     = PrimeFull[HASH_W-1:0];

    logic [HASH_W-1:0] x;

    assign x = h_i ^ {{(HASH_W-8){1'b0}}, byte_i};

    // Prime is a constant, so only its few set bits produce adders.
    always_comb begin
        h_next_o = '0;
        for (int i = 0; i < int'(HASH_W); i++) begin
            if (Prime[i]) begin
                h_next_o = h_next_o + (x << i);
            end
        end
    end

endmodule

// File: rtl/checksum_engine.sv
// Frame-based LRC / XOR / FNV-1a engine with a held, back-pressurable result.
module checksum_engine
    import checksum_pkg::*;
#(
    parameter int unsigned HASH_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    checksum_engine_if.slave  bus
);
    localparam logic [63:0]       SeedFull = fnv_offset(HASH_W);
    localparam logic [HASH_W-1:0] Seed     = SeedFull[HASH_W-1:0];
    localparam logic [CNT_W-1:0]  CntMax   = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, mode_cur;
    logic [7:0]        sum_q, sum_d, sum_upd;
    logic [7:0]        xor_q, xor_d, xor_upd;
    logic [HASH_W-1:0] hash_q, hash_d, hash_base, hash_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_upd;
    logic [HASH_W-1:0] res_data_q, res_data_d, result;
    logic [1:0]        res_mode_q, res_mode_d;
    logic [CNT_W-1:0]  res_count_q, res_count_d;
    logic              res_err_q, res_err_d;
    logic              first, in_ready, accept;
    logic [7:0]        lrc;

    // Gated by rst_n so nothing is taken while reset is held.
    assign in_ready = rst_n && (state_q != HOLD) && !bus.clear;
    assign accept   = bus.in_valid && in_ready;
    assign first    = (state_q == IDLE);

    // The first beat seeds everything; later beats build on the held state.
    assign mode_cur  = first ? mode_e'(bus.mode) : mode_q;
    assign hash_base = first ? Seed : hash_q;
    assign sum_upd   = (first ? 8'd0 : sum_q) + bus.in_data;
    assign xor_upd   = (first ? 8'd0 : xor_q) ^ bus.in_data;
    assign cnt_upd   = first ? CNT_W'(1) : ((cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1);

    fnv1a_step #(
        .HASH_W (HASH_W)
    ) u_step (
        .h_i      (hash_base),
        .byte_i   (bus.in_data),
        .h_next_o (hash_step)
    );

    // Final result of the frame if the current beat closes it.
    always_comb begin
        lrc    = 8'd0 - sum_upd;  // two's complement of the byte sum
        result = '0;
        unique case (mode_cur)
            MODE_LRC: result = {{(HASH_W-8){1'b0}}, lrc};
            MODE_XOR: result = {{(HASH_W-8){1'b0}}, xor_upd};
            MODE_FNV: result = hash_step;
            default:  result = '0;
        endcase
    end

    // Next-state: frame FSM, accumulators and result registers.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sum_d       = sum_q;
        xor_d       = xor_q;
        hash_d      = hash_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_mode_d  = res_mode_q;
        res_count_d = res_count_q;
        res_err_d   = res_err_q;

        if (bus.clear || (state_q == HOLD && bus.res_ready)) begin
            // Abort or result taken: back to the reset picture.
            state_d     = IDLE;
            mode_d      = MODE_LRC;
            sum_d       = '0;
            xor_d       = '0;
            hash_d      = Seed;
            cnt_d       = '0;
            res_data_d  = '0;
            res_mode_d  = '0;
            res_count_d = '0;
            res_err_d   = 1'b0;
        end else if (accept) begin
            mode_d  = mode_cur;
            sum_d   = sum_upd;
            xor_d   = xor_upd;
            hash_d  = hash_step;
            cnt_d   = cnt_upd;
            state_d = ACCUM;
            if (bus.in_last) begin
                state_d     = HOLD;
                res_data_d  = result;
                res_mode_d  = mode_cur;
                res_count_d = cnt_upd;
                res_err_d   = (mode_cur == MODE_RSVD);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_LRC;
            sum_q       <= '0;
            xor_q       <= '0;
            hash_q      <= Seed;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_mode_q  <= '0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sum_q       <= sum_d;
            xor_q       <= xor_d;
            hash_q      <= hash_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_mode_q  <= res_mode_d;
            res_count_q <= res_count_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = (state_q == HOLD);
    assign bus.res_data  = res_data_q;
    assign bus.res_mode  = res_mode_q;
    assign bus.res_count = res_count_q;
    assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_checksum_engine.sv
// Scoreboard bench for checksum_engine (HASH_W=32, CNT_W=4) plus a 64-bit fnv1a_step check.
module tb_checksum_engine;
    localparam int unsigned HW = 32;
    localparam int unsigned CW = 4;

    typedef struct {
        logic [HW-1:0] data;
        logic [1:0]    mode;
        logic [CW-1:0] count;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   acc_cyc = 0;
    bit   rr_auto = 1'b1;
    exp_t exp_q[$];

    logic [63:0] h64_in, h64_out;
    logic [7:0]  b64;

    checksum_engine_if #(.HASH_W(HW), .CNT_W(CW)) bus ();

    checksum_engine #(.HASH_W(HW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fnv1a_step #(.HASH_W(64)) u_step64 (
        .h_i      (h64_in),
        .byte_i   (b64),
        .h_next_o (h64_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: the frame's check computed straight from the byte list.
    function automatic exp_t model(input logic [1:0] m, input logic [7:0] bytes[$]);
        exp_t        e;
        logic [7:0]  s;
        logic [7:0]  x;
        logic [31:0] h;
        int          n;
        s = 8'd0;
        x = 8'd0;
        h = 32'h811C9DC5;
        n = bytes.size();
        foreach (bytes[i]) begin
            s = s + bytes[i];
            x = x ^ bytes[i];
            h = (h ^ {24'h0, bytes[i]}) * 32'h01000193;
        end
        e.count = (n > 15) ? 4'd15 : CW'(n);
        e.mode  = m;
        e.err   = (m == 2'b11);
        case (m)
            2'b00:   e.data = {24'h0, 8'(8'd0 - s)};
            2'b01:   e.data = {24'h0, x};
            2'b10:   e.data = h;
            default: e.data = '0;
        endcase
        return e;
    endfunction

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic [7:0] d, input logic l, input logic [1:0] m, output bit ok);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.mode     = m;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        ok = acc;
        if (!acc) fail_now("beat_accept_timeout");
    endtask

    task automatic send_frame(input logic [1:0] m, input logic [7:0] bytes[$], input int max_gap,
                              input bit toggle, input bit use_ref, input logic [HW-1:0] ref_data);
        bit   ok;
        exp_t e;
        int   n;
        n = bytes.size();
        for (int i = 0; i < n; i++) begin
            repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
                @(posedge clk);
                #1;
            end
            beat(bytes[i], (i == n - 1), (toggle && i > 0) ? 2'b10 : m, ok);
            if (!ok) return;
        end
        e = model(m, bytes);
        if (use_ref) e.data = ref_data;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || bus.res_valid) && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 500) fail_now("drain_timeout");
    endtask

    // Result consumer: random back-pressure unless the stimulus takes over.
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_auto) bus.res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each new result, then check it stays put until taken.
    initial begin
        logic was_v;
        logic hs;
        exp_t held;
        exp_t e;
        was_v = 1'b0;
        hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                was_v = 1'b0;
                hs = 1'b0;
                continue;
            end
            if (hs) begin
                check("res_valid_drop_after_handshake", bus.res_valid, 1'b0);
            end else if (bus.res_valid && !was_v) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", bus.res_data, e.data);
                    check("res_mode", bus.res_mode, e.mode);
                    check("res_count", bus.res_count, e.count);
                    check("res_err", bus.res_err, e.err);
                    check("result_latency", cyc - acc_cyc, 1);
                    held = e;
                end
            end else if (bus.res_valid && was_v) begin
                check("res_stable", {bus.res_data, bus.res_mode, bus.res_count, bus.res_err},
                      {held.data, held.mode, held.count, held.err});
            end
            hs = bus.res_valid && bus.res_ready;
            was_v = bus.res_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        bit         ok;
        exp_t       e;
        int         n;

        bus.clear    = 1'b0;
        bus.mode     = 2'b00;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        // Standalone 64-bit step: known vector then random ones.
        h64_in = 64'hCBF29CE484222325;
        b64 = 8'h61;
        #1;
        check("fnv64_a", h64_out, 64'hAF63DC4C8601EC8C);
        for (int i = 0; i < 4; i++) begin
            h64_in = {$urandom, $urandom};
            b64 = 8'($urandom);
            #1;
            check("fnv64_step_rand", h64_out, (h64_in ^ {56'h0, b64}) * 64'h00000100000001B3);
        end

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_outputs", {bus.res_data, bus.res_mode, bus.res_count, bus.res_err}, '0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed frames with known answers.
        q = {8'h61};
        send_frame(2'b10, q, 0, 1'b0, 1'b1, 32'hE40C292C);
        wait_idle();
        q = {8'h66, 8'h6f, 8'h6f, 8'h62, 8'h61, 8'h72};
        send_frame(2'b10, q, 3, 1'b0, 1'b1, 32'hBF9CF968);
        wait_idle();
        q = {8'h01, 8'h02, 8'h03};
        send_frame(2'b00, q, 0, 1'b0, 1'b1, 32'h000000FA);
        wait_idle();
        send_frame(2'b01, q, 1, 1'b0, 1'b1, 32'h00000000);
        wait_idle();
        send_frame(2'b00, q, 0, 1'b1, 1'b1, 32'h000000FA);
        wait_idle();
        send_frame(2'b11, q, 1, 1'b0, 1'b1, 32'h00000000);
        wait_idle();

        // Count saturates at 15 with CNT_W=4.
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        send_frame(2'b01, q, 0, 1'b0, 1'b0, '0);
        wait_idle();

        // Back-pressure with a queued beat.
        rr_auto = 1'b0;
        bus.res_ready = 1'b0;
        q = {8'h61};
        send_frame(2'b10, q, 0, 1'b0, 1'b1, 32'hE40C292C);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h61;
        bus.in_last  = 1'b1;
        bus.mode     = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("bp_res_valid_fell", bus.res_valid, 1'b0);
        check("bp_queued_beat_ready", bus.in_ready, 1'b1);
        if (bus.in_ready) begin
            acc_cyc = cyc;
            e.data = 32'hE40C292C;
            e.mode = 2'b10;
            e.count = 4'd1;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rr_auto = 1'b1;
        wait_idle();

        // clear in ACCUM blocks the presented beat and drops the frame.
        beat(8'h11, 1'b0, 2'b10, ok);
        beat(8'h22, 1'b0, 2'b10, ok);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        bus.in_last  = 1'b1;
        bus.clear    = 1'b1;
        @(negedge clk);
        check("clear_blocks_beat", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        q = {8'h61};
        send_frame(2'b10, q, 0, 1'b0, 1'b1, 32'hE40C292C);
        wait_idle();

        // clear in HOLD drops the result unacknowledged.
        rr_auto = 1'b0;
        bus.res_ready = 1'b0;
        q = {8'h05};
        send_frame(2'b01, q, 0, 1'b0, 1'b0, '0);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        @(negedge clk);
        check("clear_in_hold_drops", bus.res_valid, 1'b0);
        @(posedge clk);
        #1;
        rr_auto = 1'b1;

        // Async reset mid-frame.
        beat(8'h61, 1'b0, 2'b10, ok);
        beat(8'h62, 1'b0, 2'b10, ok);
        rst_n = 1'b0;
        #1;
        check("async_rst_in_ready", bus.in_ready, 1'b0);
        check("async_rst_outputs",
              {bus.res_valid, bus.res_data, bus.res_mode, bus.res_count, bus.res_err}, '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        q = {8'h61};
        send_frame(2'b10, q, 0, 1'b0, 1'b1, 32'hE40C292C);
        wait_idle();

        // Random frames against the model.
        for (int f = 0; f < 30; f++) begin
            q = {};
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            send_frame(2'($urandom_range(0, 3)), q, 2, bit'($urandom_range(0, 1)), 1'b0, '0);
            wait_idle();
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
